// File: rtl/gmii_tx_arbiter_if.sv
// gmii_tx_arbiter_if: bundles the two requester ports and the merged GMII TX bus
//   req0/req1        requester wants the bus
//   grant0/grant1    requester owns the bus (one-hot or zero)
//   tx_en0/tx_en1    requester frame enable
//   txd0/txd1        requester frame data
//   gmii_tx_en/txd   merged, registered stream toward the GMII-to-RGMII converter
//   busy             arbiter is not idle
//   timeout_err      one-cycle pulse when a grant is revoked for never starting
// master = requester/environment side, slave = arbiter side.
interface gmii_tx_arbiter_if;
    logic       req0;
    logic       req1;
    logic       grant0;
    logic       grant1;
    logic       tx_en0;
    logic       tx_en1;
    logic [7:0] txd0;
    logic [7:0] txd1;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       busy;
    logic       timeout_err;

    modport master (
        output req0, req1, tx_en0, tx_en1, txd0, txd1,
        input  grant0, grant1, gmii_tx_en, gmii_txd, busy, timeout_err
    );

    modport slave (
        input  req0, req1, tx_en0, tx_en1, txd0, txd1,
        output grant0, grant1, gmii_tx_en, gmii_txd, busy, timeout_err
    );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: shares one GMII TX bus between two frame sources with an
// enforced inter-frame gap and a start-of-frame timeout.
//   gmii_tx_clk  sole clock, rising edge
//   reset        synchronous, active-high
//   bus          gmii_tx_arbiter_if.slave (requests, grants, frame inputs,
//                merged GMII output, busy, timeout_err)
// Parameters: IFG_CYCLES (>=1) idle cycles after every frame, START_TIMEOUT
// (1..255) cycles a grant may wait for tx_en.
// Macro GMII_TX_ARB_RR_EN: round-robin between simultaneous requests; when
// undefined req0 always wins ties and no last-winner state exists.
module gmii_tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 255
) (
    input logic              gmii_tx_clk,
    input logic              reset,
    gmii_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(IFG_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, GRANT, SEND, IFG} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic [7:0]    to_cnt, to_cnt_nxt;
    logic [IW-1:0] ifg_cnt, ifg_cnt_nxt;
    logic          tmo, tmo_nxt;
    logic          sel;
    logic          active;
    logic          own_en;
    logic [7:0]    own_d;
    logic          any_req;

    assign any_req = bus.req0 || bus.req1;
    assign active  = (state == GRANT) || (state == SEND);
    assign own_en  = owner ? bus.tx_en1 : bus.tx_en0;
    assign own_d   = owner ? bus.txd1 : bus.txd0;

`ifdef GMII_TX_ARB_RR_EN
    logic last;
    // On a tie the requester that did not win last time is served.
    assign sel = (bus.req0 && bus.req1) ? ~last : bus.req1;
    always_ff @(posedge gmii_tx_clk) begin
        if (reset) last <= 1'b1;
        else if (state == IDLE && any_req) last <= sel;
    end
`else
    assign sel = ~bus.req0;
`endif

    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            to_cnt  <= '0;
            ifg_cnt <= '0;
            tmo     <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            to_cnt  <= to_cnt_nxt;
            ifg_cnt <= ifg_cnt_nxt;
            tmo     <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        to_cnt_nxt  = to_cnt;
        ifg_cnt_nxt = ifg_cnt;
        tmo_nxt     = 1'b0;
        case (state)
            IDLE: if (any_req) begin
                state_nxt  = GRANT;
                owner_nxt  = sel;
                to_cnt_nxt = '0;
            end
            // tx_en low here is still waiting for the frame to start.
            GRANT: if (own_en) begin
                state_nxt  = SEND;
                to_cnt_nxt = '0;
            end else if (to_cnt == 8'(START_TIMEOUT - 1)) begin
                state_nxt   = IFG;
                ifg_cnt_nxt = '0;
                tmo_nxt     = 1'b1;
            end else begin
                to_cnt_nxt = to_cnt + 8'd1;
            end
            SEND: if (!own_en) begin
                state_nxt   = IFG;
                ifg_cnt_nxt = '0;
            end
            IFG: if (ifg_cnt == IW'(IFG_CYCLES - 1)) state_nxt = IDLE;
                 else ifg_cnt_nxt = ifg_cnt + 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Only the owner's inputs are copied, so the other requester is isolated.
    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            bus.gmii_tx_en <= 1'b0;
            bus.gmii_txd   <= 8'h00;
        end else begin
            bus.gmii_tx_en <= active && own_en;
            bus.gmii_txd   <= active ? own_d : 8'h00;
        end
    end

    assign bus.grant0      = active && !owner;
    assign bus.grant1      = active && owner;
    assign bus.busy        = state != IDLE;
    assign bus.timeout_err = tmo;
endmodule
